pc_sequencer: RTL and testbench

- Controller that drives the fetch-stage program-counter register.
- Arbitrates every cycle between next-PC sources: sequential, branch/jump from D, interrupt entry, ERET return. Outputs the chosen NPC and the Stall_F hold strobe.
- Sequences interrupt entry and exit with a small state machine. Entry is deferred across hazard stalls and branch delay slots so the captured EPC is always restartable.

---
 rtl/pc_sequencer_pkg.sv | 28 ++
 rtl/pc_sequencer_if.sv | 33 +++
 rtl/pc_sequencer_npc_mux.sv | 48 ++++
 rtl/pc_sequencer.sv | 84 ++++++++
 tb/tb_pc_sequencer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants, FSM state encoding and redirect classes for the fetch PC sequencer.
// Pure declarations: no logic, no latency, no flow control.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

    // 2'd3 is deliberately left unnamed; the FSM folds it back to ST_RUN.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PEND    = 2'd1,
        ST_HANDLER = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        RD_SEQ    = 3'd0,
        RD_HOLD   = 3'd1,
        RD_BRANCH = 3'd2,
        RD_EXC    = 3'd3,
        RD_ERET   = 3'd4,
        RD_RESET  = 3'd5
    } redirect_e;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC bundle: pipeline status in, next-PC / stall / flush / exception strobes out.
// Wires only; the slave side is the sequencer, the master side is the surrounding pipeline.
interface pc_sequencer_if;

    logic [31:0] PC_F;
    logic        HazardStall;
    logic        IsBranch_D;
    logic        BrTaken_D;
    logic [31:0] BrTarget_D;
    logic        Eret_D;
    logic [31:0] EPC;
    logic        IntReq;
    logic        IntEnable;

    logic [31:0] NPC;
    logic        Stall_F;
    logic        FlushD;
    logic        ExcTake;
    logic [31:0] ExcEPC;

    modport master (
        output PC_F, HazardStall, IsBranch_D, BrTaken_D, BrTarget_D,
               Eret_D, EPC, IntReq, IntEnable,
        input  NPC, Stall_F, FlushD, ExcTake, ExcEPC
    );

    modport slave (
        input  PC_F, HazardStall, IsBranch_D, BrTaken_D, BrTarget_D,
               Eret_D, EPC, IntReq, IntEnable,
        output NPC, Stall_F, FlushD, ExcTake, ExcEPC
    );

endinterface

// File: rtl/pc_sequencer_npc_mux.sv
// Next-PC select: maps an already-prioritised redirect class to NPC and the F-stage strobes.
// Combinational, zero latency; the hold class asserts Stall_F and re-presents PC_F.
module pc_sequencer_npc_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  redirect_e   i_class,
    input  logic [31:0] i_pc_f,
    input  logic [31:0] i_br_target,
    input  logic [31:0] i_epc,
    output logic [31:0] o_npc,
    output logic        o_stall_f,
    output logic        o_flush_d,
    output logic        o_exc_take,
    output logic [31:0] o_exc_epc
);

    always_comb begin
        o_npc      = seq_pc(i_pc_f);
        o_stall_f  = 1'b0;
        o_flush_d  = 1'b0;
        o_exc_take = 1'b0;
        o_exc_epc  = 32'd0;
        case (i_class)
            RD_RESET:  o_npc = RESET_PC;
            RD_HOLD: begin
                o_npc     = i_pc_f;
                o_stall_f = 1'b1;
            end
            RD_BRANCH: o_npc = i_br_target;
            RD_EXC: begin
                // F holds a non-delay-slot instruction; it is squashed and becomes the EPC.
                o_npc      = EXC_VECTOR;
                o_flush_d  = 1'b1;
                o_exc_take = 1'b1;
                o_exc_epc  = i_pc_f;
            end
            RD_ERET: begin
                o_npc     = i_epc;
                o_flush_d = 1'b1;
            end
            default:   o_npc = seq_pc(i_pc_f);
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC controller: arbitrates sequential/branch/interrupt/ERET next-PC and sequences interrupt entry.
// NPC is combinational (same-cycle); only the RUN/PEND/HANDLER state is registered; Stall_F holds PC on hazards.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic           CLK,
    input  logic           RESET,
    pc_sequencer_if.slave  bus
);

    state_e    r_state;
    logic      w_int_req;
    logic      w_ok;
    logic      w_armed;
    logic      w_take;
    logic      w_eret;
    redirect_e w_class;

    // Entry is only safe when F holds neither a stalled nor a delay-slot instruction.
    assign w_int_req = bus.IntReq & bus.IntEnable;
    assign w_ok      = ~bus.HazardStall & ~bus.IsBranch_D;
    assign w_armed   = (r_state == ST_RUN) | (r_state == ST_PEND);
    assign w_take    = w_armed & w_int_req & w_ok;
    assign w_eret    = (r_state == ST_HANDLER) & bus.Eret_D & ~bus.HazardStall;

    always_comb begin
        w_class = RD_SEQ;
        if (RESET)
            w_class = RD_RESET;
        else if (w_take)
            w_class = RD_EXC;
        else if (w_eret)
            w_class = RD_ERET;
        else if (bus.HazardStall)
            w_class = RD_HOLD;
        else if (bus.BrTaken_D)
            w_class = RD_BRANCH;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_int_req && w_ok)
                        r_state <= ST_HANDLER;
                    else if (w_int_req)
                        r_state <= ST_PEND;
                end
                ST_PEND: begin
                    if (!w_int_req)
                        r_state <= ST_RUN;
                    else if (w_ok)
                        r_state <= ST_HANDLER;
                end
                ST_HANDLER: begin
                    if (w_eret)
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    pc_sequencer_npc_mux #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_npc_mux (
        .i_class     (w_class),
        .i_pc_f      (bus.PC_F),
        .i_br_target (bus.BrTarget_D),
        .i_epc       (bus.EPC),
        .o_npc       (bus.NPC),
        .o_stall_f   (bus.Stall_F),
        .o_flush_d   (bus.FlushD),
        .o_exc_take  (bus.ExcTake),
        .o_exc_epc   (bus.ExcEPC)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed walk through the interrupt/branch/ERET scenarios, then random traffic,
// all compared against a small behavioural model of the next-PC rules.
module tb_pc_sequencer;

    logic CLK;
    logic RESET;

    pc_sequencer_if bus();

    pc_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_total = 0;
    int n_pass  = 0;

    // Model state: "inside handler" flag only; a pending request needs no memory because
    // entry is simply retried every cycle the request is still live.
    bit          m_handler = 1'b0;
    logic [31:0] obs_npc, obs_epc;
    logic        obs_stall, obs_flush, obs_take;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: evaluate model, compare outputs mid-cycle, then clock and let PC_F follow NPC.
    task automatic step();
        logic [31:0] e_npc, e_epc;
        logic        e_stall, e_flush, e_take, e_eret;
        #3;
        e_stall = 1'b0; e_flush = 1'b0; e_take = 1'b0; e_epc = 32'd0;
        e_eret  = 1'b0;
        e_npc   = bus.PC_F + 32'd4;
        if (RESET) begin
            e_npc = 32'h0000_3000;
        end else begin
            e_take = !m_handler && bus.IntReq && bus.IntEnable && !bus.HazardStall && !bus.IsBranch_D;
            e_eret = m_handler && bus.Eret_D && !bus.HazardStall;
            if (e_take) begin
                e_npc = 32'h0000_4180; e_flush = 1'b1; e_epc = bus.PC_F;
            end else if (e_eret) begin
                e_npc = bus.EPC; e_flush = 1'b1;
            end else if (bus.HazardStall) begin
                e_npc = bus.PC_F; e_stall = 1'b1;
            end else if (bus.BrTaken_D) begin
                e_npc = bus.BrTarget_D;
            end
        end
        obs_npc = bus.NPC; obs_stall = bus.Stall_F; obs_flush = bus.FlushD;
        obs_take = bus.ExcTake; obs_epc = bus.ExcEPC;
        chk("npc",     obs_npc, e_npc);
        chk("stall_f", {31'd0, obs_stall}, {31'd0, e_stall});
        chk("flush_d", {31'd0, obs_flush}, {31'd0, e_flush});
        chk("exc_take", {31'd0, obs_take}, {31'd0, e_take});
        if (RESET || e_take)
            chk("exc_epc", obs_epc, e_epc);
        @(posedge CLK);
        #1;
        if (RESET)       m_handler = 1'b0;
        else if (e_take) m_handler = 1'b1;
        else if (e_eret) m_handler = 1'b0;
        bus.PC_F = e_npc;
    endtask

    task automatic idle_inputs();
        bus.HazardStall = 1'b0; bus.IsBranch_D = 1'b0; bus.BrTaken_D = 1'b0;
        bus.BrTarget_D  = 32'd0; bus.Eret_D = 1'b0; bus.EPC = 32'd0;
        bus.IntReq      = 1'b0; bus.IntEnable = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        bus.PC_F = 32'h0000_1234;
        idle_inputs();
        @(posedge CLK);
        #1;

        // Reset values, then free-running sequential fetch.
        step();
        chk("rst_npc", obs_npc, 32'h0000_3000);
        step();
        RESET = 1'b0;
        step(); chk("seq0", obs_npc, 32'h0000_3004);
        step(); chk("seq1", obs_npc, 32'h0000_3008);
        step(); chk("seq2", obs_npc, 32'h0000_300C);
        step(); chk("seq3", obs_npc, 32'h0000_3010);

        // Stalled taken branch: held twice, then redirect without flush.
        bus.HazardStall = 1'b1; bus.IsBranch_D = 1'b1; bus.BrTaken_D = 1'b1; bus.BrTarget_D = 32'h0000_3100;
        step(); chk("stall_hold0", obs_npc, 32'h0000_3010);
        step(); chk("stall_hold1", {31'd0, obs_stall}, 32'd1);
        bus.HazardStall = 1'b0;
        step(); chk("br_redirect", obs_npc, 32'h0000_3100);
        chk("br_noflush", {31'd0, obs_flush}, 32'd0);

        // Interrupt arrives over a branch: deferred one cycle past the delay slot.
        bus.PC_F = 32'h0000_3020;
        bus.IntReq = 1'b1; bus.IntEnable = 1'b1;
        step(); chk("pend_br", obs_npc, 32'h0000_3100);
        chk("pend_notake", {31'd0, obs_take}, 32'd0);
        bus.IsBranch_D = 1'b0; bus.BrTaken_D = 1'b0;
        step(); chk("entry_take", {31'd0, obs_take}, 32'd1);
        chk("entry_epc", obs_epc, 32'h0000_3100);
        chk("entry_vec", obs_npc, 32'h0000_4180);

        // No nesting while in the handler.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("no_nest", {31'd0, obs_take}, 32'd0);
        end
        bus.Eret_D = 1'b1; bus.EPC = 32'h0000_3100;
        step(); chk("eret_npc", obs_npc, 32'h0000_3100);
        chk("eret_flush", {31'd0, obs_flush}, 32'd1);
        bus.Eret_D = 1'b0;
        step(); chk("reentry", {31'd0, obs_take}, 32'd1);

        // Leave handler, then a request that goes pending and is withdrawn.
        bus.IntReq = 1'b0; bus.Eret_D = 1'b1;
        step();
        bus.Eret_D = 1'b0; bus.IntReq = 1'b1; bus.HazardStall = 1'b1;
        step();
        bus.IntReq = 1'b0; bus.HazardStall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("pend_drop", {31'd0, obs_take}, 32'd0);
        end

        // Reset from inside the handler; a later ERET is a plain sequential fetch.
        bus.IntReq = 1'b1;
        step(); chk("take_again", {31'd0, obs_take}, 32'd1);
        bus.IntReq = 1'b0;
        RESET = 1'b1;
        step(); chk("rst_handler", obs_npc, 32'h0000_3000);
        RESET = 1'b0; bus.Eret_D = 1'b1;
        step(); chk("eret_after_rst", obs_npc, 32'h0000_3004);
        chk("eret_after_rst_fl", {31'd0, obs_flush}, 32'd0);
        bus.Eret_D = 1'b0;

        // 32-bit wrap of the sequential path.
        bus.PC_F = 32'hFFFF_FFFC;
        step(); chk("wrap", obs_npc, 32'h0000_0000);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            RESET           = ($urandom_range(0, 99) == 0);
            bus.HazardStall = ($urandom_range(0, 3) == 0);
            bus.IsBranch_D  = ($urandom_range(0, 9) < 3);
            bus.BrTaken_D   = bus.IsBranch_D & $urandom_range(0, 1);
            bus.BrTarget_D  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bus.Eret_D      = ($urandom_range(0, 4) == 0);
            bus.EPC         = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bus.IntReq      = ($urandom_range(0, 4) < 2);
            bus.IntEnable   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0)
                bus.PC_F = 32'hFFFF_FFFC;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
